rover_motor_ctrl: RTL and testbench
===================================

# rover_motor_ctrl

Drive-command stage for the rover's two DC motors, fed by the proximity sensor's `isCrash` flag and by the command source (buttons/UART decoder). It turns a direction/speed command into H-bridge direction pins plus PWM enables. It inserts dead time on every direction change and latches a crash lockout that blocks forward motion while an obstacle is within range.

## Interface
- `PWM_DIV`, 390: clocks per PWM counter step (100 MHz / 256 / 390 ≈ 1 kHz PWM).
- `DEAD_CYCLES`, 100000: coast time before any new direction is driven (1 ms).
- `CRASH_FILT`, 4: consecutive equal samples needed to change the filtered crash level.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd`  in  3  direction: 0 stop, 1 fwd, 2 rev, 3 pivot left, 4 pivot right; 5–7 treated as stop.
- `cmd_valid`  in  1  one-cycle strobe; `cmd`/`speed` sampled on that edge.
- `speed`  in  8  PWM duty, 0 = off, 255 = 255/256.
- `is_crash`  in  1  level from proximity sensor, asynchronous to `clk`.
- `in1`,`in2`  out  1 each  left bridge direction.
- `in3`,`in4`  out  1 each  right bridge direction.
- `en_a`,`en_b`  out  1 each  left/right PWM enables.
- `crash_lock`  out  1  high while in LOCK.
- `busy`  out  1  high while in DEAD.

## Operation
- States: IDLE, DEAD, DRIVE, LOCK. Reset → IDLE. All outputs 0, all counters 0, stored dir = stop, stored duty = 0.
- Pin map (in1..in4) in DRIVE: fwd 1010, rev 0101, left 0110, right 1001. In IDLE/DEAD/LOCK: in1..in4 = 0000 and en_a = en_b = 0 (coast).
- `is_crash` path: 2-flop sync, then filter. `crash_f` rises after CRASH_FILT consecutive synced 1s and falls after CRASH_FILT consecutive 0s.
- Accepted command, from IDLE or DRIVE:
  - stop → IDLE immediately.
  - Same dir as current DRIVE → stay in DRIVE and update pending duty only.
  - Any other dir → DEAD with pending dir and duty.
- DEAD: counts DEAD_CYCLES clocks, then enters DRIVE with the pending dir. A new accepted command during DEAD replaces the pending dir/duty and restarts the count. stop during DEAD → IDLE.
- Crash: when `crash_f` = 1 and (DRIVE with dir fwd, or DEAD with pending fwd) → LOCK.
- Forward gating: while `crash_f` = 1, fwd commands are dropped in every state, and the stored state is unchanged.
- LOCK exit:
  - stop → IDLE.
  - rev/left/right → DEAD.
  - fwd → DEAD only once `crash_f` = 0.
  - LOCK never exits on its own.
- Priority: the crash transition beats `cmd_valid` in the same cycle, and that command is dropped.
- PWM:
  - Prescaler counts 0..PWM_DIV-1. On its terminal count, the 8-bit `pwm_cnt` increments and wraps 255→0.
  - en_a = en_b = (state == DRIVE) && (pwm_cnt < duty).
  - The active duty loads from the pending duty only at the `pwm_cnt` 255→0 wrap, so there are no mid-period glitches. On entry to DRIVE from DEAD, duty loads immediately and `pwm_cnt` and the prescaler reset to 0.

## Timing
- All outputs are registered. The state change occurs on the edge after the `cmd_valid` sample. Pin/enable outputs follow state one cycle later, so command-to-pin latency is 2 clocks.
- Crash latency from an `is_crash` rise to en = 0 is 2 (sync) + CRASH_FILT + 2 clocks = 8 at defaults, and must not exceed this.
- DEAD lasts exactly DEAD_CYCLES clocks: `busy` is high for DEAD_CYCLES cycles, then in1..in4 take the new value on the next cycle.
- Speed change within the same dir takes effect at the next PWM wrap, at most 256·PWM_DIV clocks later.
- `rst` asserted mid-operation: all outputs drop to 0 asynchronously, with no dead-time wait. Operation resumes in IDLE after release.

## Test plan
Bench parameters: PWM_DIV=1, DEAD_CYCLES=8, CRASH_FILT=4.
- Reset, then cmd=1, speed=64, one valid strobe → busy high for 8 clocks; then in=1010, en high for 64 of each 256-clock period.
- Driving fwd, issue cmd=2 → en drops within 2 clocks, in=0000 for the 8 DEAD cycles, then in=0101.
- Driving fwd, raise `is_crash` → en=0 and crash_lock=1 within 8 clocks. A fwd command is then dropped and the state stays LOCK. cmd=2 → DEAD → DRIVE rev.
- `crash_f`=1 while idle: cmd=1 is dropped (in=0000); cmd=4 → in=1001 after dead time. Drop `is_crash` for 4+ clocks: cmd=1 is accepted.
- Driving at speed=200, change to speed=10 mid-period → the duty switches only at the pwm_cnt wrap. speed=0 → en never high. speed=255 → en low exactly 1 clock per period.
- Assert `rst` during DEAD and during DRIVE → all outputs 0 the same cycle. After release, the state is IDLE.

Source files
------------

// File: rtl/rover_motor_ctrl.sv
// Two-motor drive stage: command to H-bridge pins and PWM enables,
// with dead time on direction changes and a forward-blocking crash lockout.
module rover_motor_ctrl #(
  parameter int PWM_DIV     = 390,
  parameter int DEAD_CYCLES = 100000,
  parameter int CRASH_FILT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  input  logic [7:0] speed,
  input  logic       is_crash,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       en_a,
  output logic       en_b,
  output logic       crash_lock,
  output logic       busy
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int FW = (CRASH_FILT > 1) ? $clog2(CRASH_FILT) : 1;

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, LOCK} state_t;
  typedef enum logic [2:0] {
    D_STOP, D_FWD, D_REV, D_LEFT, D_RIGHT
  } dir_t;

  state_t        state;
  dir_t          dir, pend_dir, cdir;
  logic [7:0]    duty, pend_duty, pwm_cnt;
  logic [PW-1:0] pre;
  logic [DW-1:0] dcnt;
  logic [FW-1:0] fcnt;
  logic          sync1, sync2, crash_f;
  logic [2:0]    cmd_q;
  logic [7:0]    spd_q;
  logic          vld_q;
  logic          acc, crash_hit, pre_tc;

  always_comb begin
    cdir = D_STOP;
    if (cmd_q <= 3'd4) cdir = dir_t'(cmd_q);
  end

  // fwd commands vanish while an obstacle is in range
  assign acc = vld_q && !(crash_f && cdir == D_FWD);
  assign crash_hit = crash_f &&
    ((state == DRIVE && dir == D_FWD) ||
     (state == DEAD && pend_dir == D_FWD));
  assign pre_tc = (pre == PW'(PWM_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      crash_f <= 1'b0;
      fcnt    <= '0;
      cmd_q   <= '0;
      spd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      sync1 <= is_crash;
      sync2 <= sync1;
      cmd_q <= cmd;
      spd_q <= speed;
      vld_q <= cmd_valid;
      if (sync2 != crash_f) begin
        if (fcnt == FW'(CRASH_FILT - 1)) begin
          crash_f <= sync2;
          fcnt    <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= D_STOP;
      pend_dir  <= D_STOP;
      duty      <= '0;
      pend_duty <= '0;
      pwm_cnt   <= '0;
      pre       <= '0;
      dcnt      <= '0;
    end else begin
      pre <= pre_tc ? '0 : pre + PW'(1);
      if (pre_tc) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) duty <= pend_duty;
      end
      if (crash_hit) begin
        state <= LOCK;
        dir   <= D_STOP;
      end else if (acc) begin
        if (cdir == D_STOP) begin
          state <= IDLE;
          dir   <= D_STOP;
        end else if (state == DRIVE && cdir == dir) begin
          pend_duty <= spd_q;
        end else begin
          state     <= DEAD;
          dir       <= D_STOP;
          pend_dir  <= cdir;
          pend_duty <= spd_q;
          dcnt      <= '0;
        end
      end else if (state == DEAD) begin
        if (dcnt == DW'(DEAD_CYCLES - 1)) begin
          state   <= DRIVE;
          dir     <= pend_dir;
          duty    <= pend_duty;
          pwm_cnt <= '0;
          pre     <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {in1, in2, in3, in4} <= 4'b0000;
      en_a       <= 1'b0;
      en_b       <= 1'b0;
      crash_lock <= 1'b0;
      busy       <= 1'b0;
    end else begin
      {in1, in2, in3, in4} <= 4'b0000;
      if (state == DRIVE) begin
        case (dir)
          D_FWD:   {in1, in2, in3, in4} <= 4'b1010;
          D_REV:   {in1, in2, in3, in4} <= 4'b0101;
          D_LEFT:  {in1, in2, in3, in4} <= 4'b0110;
          D_RIGHT: {in1, in2, in3, in4} <= 4'b1001;
          default: {in1, in2, in3, in4} <= 4'b0000;
        endcase
      end
      en_a       <= (state == DRIVE) && (pwm_cnt < duty);
      en_b       <= (state == DRIVE) && (pwm_cnt < duty);
      crash_lock <= (state == LOCK);
      busy       <= (state == DEAD);
    end
  end

endmodule

// File: tb/tb_rover_motor_ctrl.sv
// Directed bench for rover_motor_ctrl: vector table plus
// crash, duty-switch and reset sequences.
module tb_rover_motor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] speed = '0;
  logic       is_crash = 1'b0;
  logic       in1, in2, in3, in4, en_a, en_b, crash_lock, busy;
  logic [3:0] pins;

  int checks = 0;
  int errors = 0;

  assign pins = {in1, in2, in3, in4};

  rover_motor_ctrl #(
    .PWM_DIV(1), .DEAD_CYCLES(8), .CRASH_FILT(4)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid),
    .speed(speed), .is_crash(is_crash),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .en_a(en_a), .en_b(en_b),
    .crash_lock(crash_lock), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] c;
    logic [7:0] s;
    int         nbusy;
    logic [3:0] pins;
    int         nen;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] s);
    cmd = c;
    speed = s;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic window(output int nb, output int early);
    nb = 0;
    early = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy) nb++;
      if (i == 2) early = {pins, en_a, en_b};
    end
  endtask

  task automatic count_en(input int n, output int na, output int nb);
    na = 0;
    nb = 0;
    repeat (n) begin
      tick();
      if (en_a) na++;
      if (en_b) nb++;
    end
  endtask

  task automatic wait_busy(input logic v, input string n);
    int k = 0;
    while (busy !== v && k < 20) begin
      tick();
      k++;
    end
    chk(n, int'(busy), int'(v));
  endtask

  task automatic all_zero(input string n);
    chk(n, int'({pins, en_a, en_b, crash_lock, busy}), 0);
  endtask

  initial begin
    int nb, early, na, nbb;
    tv[0] = '{3'd1, 8'd64,  8, 4'b1010, 64};
    tv[1] = '{3'd1, 8'd255, 0, 4'b1010, 255};
    tv[2] = '{3'd2, 8'd0,   8, 4'b0101, 0};
    tv[3] = '{3'd3, 8'd128, 8, 4'b0110, 128};
    tv[4] = '{3'd4, 8'd1,   8, 4'b1001, 1};
    tv[5] = '{3'd6, 8'd100, 0, 4'b0000, 0};
    tv[6] = '{3'd4, 8'd200, 8, 4'b1001, 200};
    tv[7] = '{3'd0, 8'd0,   0, 4'b0000, 0};

    #1;
    all_zero("reset_outputs");
    tick();
    tick();
    rst = 1'b0;
    tick();
    all_zero("idle_after_reset");

    for (int i = 0; i < 8; i++) begin
      send(tv[i].c, tv[i].s);
      window(nb, early);
      chk($sformatf("v%0d_busy_cycles", i), nb, tv[i].nbusy);
      if (tv[i].nbusy > 0)
        chk($sformatf("v%0d_coast", i), early, 0);
      chk($sformatf("v%0d_pins", i), int'(pins), int'(tv[i].pins));
      repeat (256) tick();
      count_en(256, na, nbb);
      chk($sformatf("v%0d_en_a_count", i), na, tv[i].nen);
      chk($sformatf("v%0d_en_b_count", i), nbb, tv[i].nen);
    end

    send(3'd1, 8'd128);
    window(nb, early);
    chk("crash_pre_pins", int'(pins), 4'b1010);
    is_crash = 1'b1;
    repeat (8) tick();
    chk("crash_lock_latency", int'(crash_lock), 1);
    chk("crash_en_off", int'({pins, en_a, en_b}), 0);
    send(3'd1, 8'd50);
    window(nb, early);
    chk("lock_fwd_dropped_busy", nb, 0);
    chk("lock_fwd_dropped_lock", int'(crash_lock), 1);
    send(3'd2, 8'd50);
    window(nb, early);
    chk("lock_rev_busy", nb, 8);
    chk("lock_rev_pins", int'(pins), 4'b0101);
    chk("lock_rev_unlocked", int'(crash_lock), 0);

    send(3'd0, 8'd0);
    window(nb, early);
    send(3'd1, 8'd50);
    window(nb, early);
    chk("idle_fwd_gated_busy", nb, 0);
    chk("idle_fwd_gated_pins", int'(pins), 0);
    send(3'd4, 8'd30);
    window(nb, early);
    chk("idle_right_busy", nb, 8);
    chk("idle_right_pins", int'(pins), 4'b1001);
    is_crash = 1'b0;
    repeat (10) tick();
    send(3'd1, 8'd40);
    window(nb, early);
    chk("clear_fwd_busy", nb, 8);
    chk("clear_fwd_pins", int'(pins), 4'b1010);
    count_en(256, na, nbb);
    chk("clear_fwd_en", na, 40);

    send(3'd0, 8'd0);
    window(nb, early);
    send(3'd1, 8'd200);
    wait_busy(1'b1, "dc_busy_rise");
    wait_busy(1'b0, "dc_busy_fall");
    chk("dc_first_en", int'(en_a), 1);
    repeat (49) tick();
    send(3'd1, 8'd10);
    count_en(205, na, nbb);
    chk("dc_old_duty_rest", na, 149);
    count_en(256, na, nbb);
    chk("dc_new_duty", na, 10);

    send(3'd2, 8'd20);
    repeat (4) tick();
    chk("rst_dead_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    all_zero("rst_dead_outputs");
    tick();
    tick();
    rst = 1'b0;
    window(nb, early);
    chk("rst_dead_idle_busy", nb, 0);
    all_zero("rst_dead_idle");

    send(3'd1, 8'd255);
    window(nb, early);
    chk("post_rst_busy", nb, 8);
    chk("drive_before_rst", int'({pins, en_a}), 5'b10101);
    rst = 1'b1;
    #1;
    all_zero("rst_drive_outputs");
    tick();
    rst = 1'b0;
    window(nb, early);
    chk("rst_drive_idle_busy", nb, 0);
    all_zero("rst_drive_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
